// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, LSB first, one bit per clock
// Operands shift right through a single full-adder cell; SUM/COUT update only on completion.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic ha1_s;
  logic bit_s;
  logic bit_c;

  // Two cascaded half adders: operands first, then the stored carry.
  always_comb begin
    ha1_s = a_q[0] ^ b_q[0];
    bit_s = ha1_s ^ carry_q;
    bit_c = (a_q[0] & b_q[0]) | (carry_q & ha1_s);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        acc_d            = acc_q >> 1;
        acc_d[WIDTH-1]   = bit_s;
        carry_d          = bit_c;
        cnt_d            = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = acc_d;
          cout_d  = bit_c;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY = (state_q == SHIFT);
  assign DONE = (state_q == FIN);
  assign SUM  = sum_q;
  assign COUT = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=8)
// Table vectors, hand sequences for reset/START corner cases, random ops vs A+B reference.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         COUT;

  int tests;
  int fails;
  logic [W:0] prev_res;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .START(START),
    .A    (A),
    .B    (B),
    .BUSY (BUSY),
    .DONE (DONE),
    .SUM  (SUM),
    .COUT (COUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the FIN cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hold_start, input bit poke_start,
                       output logic [W:0] res);
    logic [W:0] expv;
    expv  = {1'b0, a} + {1'b0, b};
    START = 1'b1;
    A     = a;
    B     = b;
    @(posedge CLK);
    @(negedge CLK);
    START = hold_start;
    A     = W'($urandom);
    B     = W'($urandom);
    for (int k = 1; k <= W; k++) begin
      chk("busy_in_shift", 32'(BUSY), 32'd1);
      chk("no_done_in_shift", 32'(DONE), 32'd0);
      chk("result_held", 32'({COUT, SUM}), 32'(prev_res));
      if (poke_start) START = k[0];
      A = W'($urandom);
      B = W'($urandom);
      @(posedge CLK);
      @(negedge CLK);
    end
    chk("done_pulse", 32'(DONE), 32'd1);
    chk("busy_off_in_fin", 32'(BUSY), 32'd0);
    chk("result", 32'({COUT, SUM}), 32'(expv));
    prev_res = expv;
    @(posedge CLK);
    @(negedge CLK);
    chk("done_one_cycle", 32'(DONE), 32'd0);
    chk("idle_after_fin", 32'(BUSY), 32'd0);
    chk("result_hold_idle", 32'({COUT, SUM}), 32'(expv));
    START = 1'b0;
    res   = expv;
  endtask

  initial begin
    vec_t vecs[6];
    logic [W:0] r;
    logic [W-1:0] ra, rb;

    vecs[0] = '{a: 8'h00, b: 8'h00, exp_sum: 8'h00, exp_cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, exp_sum: 8'h00, exp_cout: 1'b1};
    vecs[2] = '{a: 8'h5A, b: 8'hA5, exp_sum: 8'hFF, exp_cout: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h80, exp_sum: 8'h00, exp_cout: 1'b1};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, exp_sum: 8'hFE, exp_cout: 1'b1};
    vecs[5] = '{a: 8'h37, b: 8'h19, exp_sum: 8'h50, exp_cout: 1'b0};

    tests    = 0;
    fails    = 0;
    prev_res = '0;
    RST_N    = 1'b0;
    START    = 1'b0;
    A        = 8'hAA;
    B        = 8'h55;
    #2;
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    chk("reset_result", 32'({COUT, SUM}), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // Idle with START low: nothing moves.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("idle_busy", 32'(BUSY), 32'd0);
      chk("idle_done", 32'(DONE), 32'd0);
    end

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, 1'b0, 1'b0, r);
      chk("vec_sum", 32'(SUM), 32'(vecs[i].exp_sum));
      chk("vec_cout", 32'(COUT), 32'(vecs[i].exp_cout));
    end

    // START pulsed during BUSY is ignored.
    do_op(8'h21, 8'h43, 1'b0, 1'b1, r);
    chk("poke_sum", 32'(SUM), 32'h64);

    // START held high: accepted every W+2 cycles, each result from its own operands.
    for (int i = 0; i < 5; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, 1'b1, 1'b0, r);
    end

    // Reset mid-operation at E4.
    START = 1'b1;
    A     = 8'h12;
    B     = 8'h34;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_result", 32'({COUT, SUM}), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    prev_res = '0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge CLK);
      chk("abort_no_done", 32'(DONE), 32'd0);
      chk("abort_idle", 32'(BUSY), 32'd0);
    end
    do_op(8'h03, 8'h04, 1'b0, 1'b0, r);
    chk("post_reset_sum", 32'(SUM), 32'h07);
    chk("post_reset_cout", 32'(COUT), 32'd0);

    // Start accepted on the first edge after reset release.
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N    = 1'b1;
    prev_res = '0;
    do_op(8'hC0, 8'h41, 1'b0, 1'b0, r);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), r);
      chk("rand_model", 32'({COUT, SUM}), 32'(ra) + 32'(rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
